// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: segment patterns {a,b,c,d,e,f,g}
// with a as MSB, plus prescaler sizing helpers.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'h7E;
    localparam logic [6:0] SEG_1     = 7'h30;
    localparam logic [6:0] SEG_2     = 7'h6D;
    localparam logic [6:0] SEG_3     = 7'h79;
    localparam logic [6:0] SEG_4     = 7'h33;
    localparam logic [6:0] SEG_5     = 7'h5B;
    localparam logic [6:0] SEG_6     = 7'h5F;
    localparam logic [6:0] SEG_7     = 7'h70;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h7B;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [6:0] SEG_HEX_A = 7'h77;
    localparam logic [6:0] SEG_HEX_B = 7'h1F;
    localparam logic [6:0] SEG_HEX_C = 7'h4E;
    localparam logic [6:0] SEG_HEX_D = 7'h3D;
    localparam logic [6:0] SEG_HEX_E = 7'h4F;
    localparam logic [6:0] SEG_HEX_F = 7'h47;

    localparam int unsigned SEG7_SCAN_DIV_DEF = 1000;

    // Prescaler width for a given slot length; never narrower than one bit.
    function automatic int unsigned seg7_presc_w(input int unsigned scan_div);
        return (scan_div > 1) ? $clog2(scan_div) : 1;
    endfunction

    localparam int unsigned SEG7_PRESC_W_DEF = seg7_presc_w(SEG7_SCAN_DIV_DEF);

endpackage : seg7_pkg

// File: rtl/seg7_decode.sv
// Combinational 4-bit value to 7-segment pattern decoder.
// Define SEG7_HEX_DECODE_EN to show A..F for values 10..15; otherwise they are blank.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] i_val,
    output logic [6:0] o_seg_c
);

    always_comb begin
        o_seg_c = SEG_BLANK;
        case (i_val)
            4'd0:    o_seg_c = SEG_0;
            4'd1:    o_seg_c = SEG_1;
            4'd2:    o_seg_c = SEG_2;
            4'd3:    o_seg_c = SEG_3;
            4'd4:    o_seg_c = SEG_4;
            4'd5:    o_seg_c = SEG_5;
            4'd6:    o_seg_c = SEG_6;
            4'd7:    o_seg_c = SEG_7;
            4'd8:    o_seg_c = SEG_8;
            4'd9:    o_seg_c = SEG_9;
`ifdef SEG7_HEX_DECODE_EN
            4'd10:   o_seg_c = SEG_HEX_A;
            4'd11:   o_seg_c = SEG_HEX_B;
            4'd12:   o_seg_c = SEG_HEX_C;
            4'd13:   o_seg_c = SEG_HEX_D;
            4'd14:   o_seg_c = SEG_HEX_E;
            4'd15:   o_seg_c = SEG_HEX_F;
`endif
            default: o_seg_c = SEG_BLANK;
        endcase
    end

endmodule : seg7_decode

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed DIGITS-digit 7-segment driver with frame-consistent shadow and
// leading-zero blanking. Optional hex glyphs for 10..15 via SEG7_HEX_DECODE_EN.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned DIGITS         = 2,
    parameter int unsigned SCAN_DIV       = SEG7_SCAN_DIV_DEF,
    parameter bit          SEL_ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   num,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  blank_en,
    output logic [6:0]            seg7,
    output logic                  dp,
    output logic [DIGITS-1:0]     sel,
    output logic                  frame_done
);

    localparam int unsigned PRESC_W = seg7_presc_w(SCAN_DIV);
    localparam int unsigned IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(DIGITS - 1);
    localparam logic [DIGITS-1:0]  SEL_IDLE   = SEL_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    logic [PRESC_W-1:0]  r_presc;
    logic [IDX_W-1:0]    r_idx;
    logic [4*DIGITS-1:0] r_sh_num;
    logic [DIGITS-1:0]   r_sh_dp;
    logic                r_sh_blank;

    logic                w_tick;
    logic                w_slot_start;
    logic                w_load;
    logic                w_frame_end;
    logic [IDX_W-1:0]    w_idx_next;
    logic [3:0]          w_digit;
    logic                w_dp_cur;
    logic [DIGITS-1:0]   w_onehot;
    logic [DIGITS-1:0]   w_zero_from;
    logic                w_blank_cur;
    logic [6:0]          w_seg_dec;
    logic [DIGITS-1:0]   w_sel_next;

    // Slot/frame timing decoded from the scan counters.
    always_comb begin
        w_tick       = (r_presc == PRESC_LAST);
        w_slot_start = (r_presc == '0);
        w_load       = w_slot_start && (r_idx == '0);
        w_frame_end  = w_tick && (r_idx == IDX_LAST);
        w_idx_next   = (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
    end

    // Pick the shadow digit and decimal point for the current index.
    always_comb begin
        w_digit  = r_sh_num[3:0];
        w_dp_cur = r_sh_dp[0];
        w_onehot = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_digit     = r_sh_num[4*i +: 4];
                w_dp_cur    = r_sh_dp[i];
                w_onehot[i] = 1'b1;
            end
        end
    end

    // w_zero_from[i] is set when digit i and every higher digit hold value 0.
    always_comb begin
        w_zero_from = '0;
        w_zero_from[DIGITS-1] = (r_sh_num[4*DIGITS-1 -: 4] == 4'd0);
        for (int i = int'(DIGITS) - 2; i >= 0; i--) begin
            w_zero_from[i] = w_zero_from[i+1] && (r_sh_num[4*i +: 4] == 4'd0);
        end
    end

    // Digit 0 is never blanked so a zero value still shows a single 0.
    always_comb begin
        w_blank_cur = r_sh_blank && (r_idx != '0) && ((w_zero_from & w_onehot) != '0);
        w_sel_next  = SEL_IDLE;
        if (!w_slot_start) begin
            w_sel_next = SEL_ACTIVE_LOW ? ~w_onehot : w_onehot;
        end
    end

    seg7_decode u_decode (
        .i_val   (w_digit),
        .o_seg_c (w_seg_dec)
    );

    // Scan counters, shadow capture at frame start, and the registered pin stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc    <= '0;
            r_idx      <= '0;
            r_sh_num   <= '0;
            r_sh_dp    <= '0;
            r_sh_blank <= 1'b0;
            seg7       <= SEG_BLANK;
            dp         <= 1'b0;
            sel        <= SEL_IDLE;
            frame_done <= 1'b0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + PRESC_W'(1);
            if (w_tick) begin
                r_idx <= w_idx_next;
            end
            if (w_load) begin
                r_sh_num   <= num;
                r_sh_dp    <= dp_in;
                r_sh_blank <= blank_en;
            end
            seg7       <= w_blank_cur ? SEG_BLANK : w_seg_dec;
            dp         <= w_dp_cur;
            sel        <= w_sel_next;
            frame_done <= w_frame_end;
        end
    end

endmodule : seg7_scan_driver
